// File: rtl/ready_barrier.sv
// N-channel sticky ready-flag collector with an ALL/ANY barrier.
// Emits per-flag rise strobes plus one done or timeout pulse per window.
module ready_barrier #(
   parameter int NCH     = 4,
   parameter int TIMEOUT = 20,
   parameter int TW      = 8,
   localparam int CW     = $clog2(NCH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           arm,
   input  logic           mode_any,
   input  logic [NCH-1:0] set_i,
   input  logic [NCH-1:0] clr_i,
   output logic [NCH-1:0] ready_o,
   output logic [NCH-1:0] rise_o,
   output logic [CW-1:0]  count_o,
   output logic           busy_o,
   output logic           done_o,
   output logic           timeout_o
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT);
   localparam bit            TEN   = (TIMEOUT != 0);

   state_t         state;
   state_t         state_n;
   logic [TW-1:0]  cnt;
   logic [TW-1:0]  cnt_n;
   logic [NCH-1:0] ready_n;
   logic [NCH-1:0] upd;
   logic           tmo_n;
   logic           cond;

   function automatic logic [CW-1:0] popcnt(input logic [NCH-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < NCH; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // Set wins over a simultaneous clear.
   always_comb begin
      upd  = set_i | (ready_o & ~clr_i);
      cond = mode_any ? |ready_o : &ready_o;
   end

   always_comb begin
      state_n = state;
      ready_n = ready_o;
      cnt_n   = cnt;
      tmo_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (arm) begin
               ready_n = '0;
               cnt_n   = TLOAD;
               state_n = WAIT;
            end else begin
               ready_n = upd;
            end
         end
         WAIT: begin
            if (arm) begin
               ready_n = '0;
               cnt_n   = TLOAD;
            end else begin
               ready_n = upd;
               if (cond) begin
                  state_n = DONE;
               end else if (TEN && cnt == '0) begin
                  tmo_n   = 1'b1;
                  state_n = IDLE;
               end else if (cnt != '0) begin
                  cnt_n = cnt - 1'b1;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ready_o   <= '0;
         rise_o    <= '0;
         count_o   <= '0;
         timeout_o <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ready_o   <= ready_n;
         rise_o    <= ready_n & ~ready_o;
         count_o   <= popcnt(ready_n);
         timeout_o <= tmo_n;
      end
   end

   always_comb begin
      busy_o = (state == WAIT);
      done_o = (state == DONE);
   end

endmodule

// File: tb/tb_ready_barrier.sv
// Directed bench for ready_barrier: three instances with TIMEOUT 20, 5, 0
// share one stimulus stream.
module tb_ready_barrier;

   logic       clk;
   logic       rst;
   logic       arm;
   logic       mode_any;
   logic [3:0] set_i;
   logic [3:0] clr_i;

   logic [3:0] ready_a, rise_a, ready_b, rise_b, ready_c, rise_c;
   logic [2:0] count_a, count_b, count_c;
   logic       busy_a, done_a, tmo_a;
   logic       busy_b, done_b, tmo_b;
   logic       busy_c, done_c, tmo_c;

   int checks;
   int errors;
   int cyc;

   ready_barrier #(.NCH(4), .TIMEOUT(20), .TW(8)) dut_a (
      .clk(clk), .rst(rst), .arm(arm), .mode_any(mode_any),
      .set_i(set_i), .clr_i(clr_i),
      .ready_o(ready_a), .rise_o(rise_a), .count_o(count_a),
      .busy_o(busy_a), .done_o(done_a), .timeout_o(tmo_a)
   );

   ready_barrier #(.NCH(4), .TIMEOUT(5), .TW(8)) dut_b (
      .clk(clk), .rst(rst), .arm(arm), .mode_any(mode_any),
      .set_i(set_i), .clr_i(clr_i),
      .ready_o(ready_b), .rise_o(rise_b), .count_o(count_b),
      .busy_o(busy_b), .done_o(done_b), .timeout_o(tmo_b)
   );

   ready_barrier #(.NCH(4), .TIMEOUT(0), .TW(8)) dut_c (
      .clk(clk), .rst(rst), .arm(arm), .mode_any(mode_any),
      .set_i(set_i), .clr_i(clr_i),
      .ready_o(ready_c), .rise_o(rise_c), .count_o(count_c),
      .busy_o(busy_c), .done_o(done_c), .timeout_o(tmo_c)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      arm      = 1'b0;
      mode_any = 1'b0;
      set_i    = '0;
      clr_i    = '0;
      tick();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      clk      = 1'b0;
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      rst      = 1'b1;
      arm      = 1'b0;
      mode_any = 1'b0;
      set_i    = '0;
      clr_i    = '0;
      tick();
      tick();
      chk("rst_ready", 32'(ready_a), 32'h0);
      chk("rst_rise", 32'(rise_a), 32'h0);
      chk("rst_count", 32'(count_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_done", 32'(done_a), 32'h0);
      chk("rst_tmo", 32'(tmo_a), 32'h0);

      // ALL mode, flags arrive over several cycles
      rst = 1'b0;
      cyc = 0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("t1_busy1", 32'(busy_a), 32'h1);
      tick();
      set_i = 4'b0001;
      tick();
      set_i = 4'b0100;
      chk("t1_rise3", 32'(rise_a), 32'h1);
      chk("t1_ready3", 32'(ready_a), 32'h1);
      tick();
      set_i = 4'b0000;
      chk("t1_rise4", 32'(rise_a), 32'h4);
      tick();
      set_i = 4'b1010;
      chk("t1_rise5", 32'(rise_a), 32'h0);
      chk("t1_done5", 32'(done_a), 32'h0);
      tick();
      set_i = 4'b0000;
      chk("t1_ready6", 32'(ready_a), 32'hf);
      chk("t1_count6", 32'(count_a), 32'h4);
      chk("t1_rise6", 32'(rise_a), 32'ha);
      chk("t1_done6", 32'(done_a), 32'h0);
      chk("t1_busy6", 32'(busy_a), 32'h1);
      tick();
      chk("t1_done7", 32'(done_a), 32'h1);
      chk("t1_busy7", 32'(busy_a), 32'h0);
      chk("t1_tmo7", 32'(tmo_a), 32'h0);
      tick();
      chk("t1_done8", 32'(done_a), 32'h0);
      chk("t1_busy8", 32'(busy_a), 32'h0);

      // ANY mode
      do_reset();
      mode_any = 1'b1;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      tick();
      tick();
      set_i = 4'b0010;
      tick();
      set_i = 4'b0000;
      chk("t2_ready5", 32'(ready_a), 32'h2);
      chk("t2_done5", 32'(done_a), 32'h0);
      tick();
      chk("t2_done6", 32'(done_a), 32'h1);
      chk("t2_done6b", 32'(done_b), 32'h1);
      tick();
      chk("t2_done7", 32'(done_a), 32'h0);
      tick();
      set_i = 4'b0001;
      tick();
      set_i = 4'b0000;
      chk("t2_rise9", 32'(rise_a), 32'h1);
      chk("t2_ready9", 32'(ready_a), 32'h3);
      chk("t2_done9", 32'(done_a), 32'h0);
      tick();
      chk("t2_done10", 32'(done_a), 32'h0);

      // timeout with partial flags; TIMEOUT=0 never expires
      do_reset();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      set_i = 4'b0011;
      chk("t3_busyc1", 32'(busy_c), 32'h1);
      tick();
      set_i = 4'b0000;
      while (cyc <= 101) begin
         chk("t3_busyc", 32'(busy_c), 32'h1);
         chk("t3_tmoc", 32'(tmo_c), 32'h0);
         chk("t3_tmoa", 32'(tmo_a), 32'(cyc == 22));
         chk("t3_donea", 32'(done_a), 32'h0);
         if (cyc <= 10) begin
            chk("t3_tmob", 32'(tmo_b), 32'(cyc == 7));
            chk("t3_doneb", 32'(done_b), 32'h0);
            chk("t3_busyb", 32'(busy_b), 32'(cyc < 7));
         end
         tick();
      end

      // set and clear together, repeated set, clear then set
      do_reset();
      set_i = 4'b0001;
      clr_i = 4'b0001;
      tick();
      chk("t4_ready1", 32'(ready_a), 32'h1);
      chk("t4_rise1", 32'(rise_a), 32'h1);
      clr_i = 4'b0000;
      tick();
      chk("t4_rise2", 32'(rise_a), 32'h0);
      chk("t4_ready2", 32'(ready_a), 32'h1);
      tick();
      chk("t4_rise3", 32'(rise_a), 32'h0);
      set_i = 4'b0000;
      clr_i = 4'b0001;
      tick();
      chk("t4_ready4", 32'(ready_a), 32'h0);
      set_i = 4'b0001;
      clr_i = 4'b0000;
      tick();
      set_i = 4'b0000;
      chk("t4_rise5", 32'(rise_a), 32'h1);
      chk("t4_count5", 32'(count_a), 32'h1);

      // re-arm mid-window reloads the counter
      do_reset();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      set_i = 4'b0011;
      tick();
      set_i = 4'b0100;
      tick();
      set_i = 4'b0000;
      chk("t5_ready3", 32'(ready_a), 32'h7);
      tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("t5_ready5", 32'(ready_a), 32'h0);
      chk("t5_rise5", 32'(rise_a), 32'h0);
      chk("t5_count5", 32'(count_a), 32'h0);
      chk("t5_busy5", 32'(busy_a), 32'h1);
      chk("t5_busyb5", 32'(busy_b), 32'h1);
      tick();
      set_i = 4'b1111;
      tick();
      set_i = 4'b0000;
      chk("t5_ready7", 32'(ready_a), 32'hf);
      while (cyc <= 12) begin
         chk("t5_donea", 32'(done_a), 32'(cyc == 8));
         chk("t5_doneb", 32'(done_b), 32'(cyc == 8));
         chk("t5_tmob", 32'(tmo_b), 32'h0);
         tick();
      end

      // reset in the middle of a window
      do_reset();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      set_i = 4'b0011;
      tick();
      set_i = 4'b0000;
      chk("t6_ready2", 32'(ready_a), 32'h3);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_ready5", 32'(ready_a), 32'h0);
      chk("t6_rise5", 32'(rise_a), 32'h0);
      chk("t6_count5", 32'(count_a), 32'h0);
      chk("t6_busy5", 32'(busy_a), 32'h0);
      while (cyc <= 40) begin
         chk("t6_donea", 32'(done_a), 32'h0);
         chk("t6_tmoa", 32'(tmo_a), 32'h0);
         chk("t6_doneb", 32'(done_b), 32'h0);
         chk("t6_tmob", 32'(tmo_b), 32'h0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
